note_step_sequencer: RTL

- Step sequencer and controller that drives the active-low note-enable bus of the synth module.
- In IDLE it passes manual keys through, registered; in PLAY it steps through a programmable pattern of note masks at a fixed step rate, with an articulation gap between steps.
- Sits between the pad inputs and the synth core, sharing the note bus between manual play and playback.

---
 rtl/synth_pkg.sv | 15 +
 rtl/step_timer.sv | 37 +++
 rtl/note_step_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// Shared types and constants for the note bus controllers.
// Pure declarations; no logic, no latency.
package synth_pkg;

    localparam int NNOTES_DEF = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } seq_state_t;

    localparam logic [NNOTES_DEF-1:0] ENN_ALL_OFF = '1;

endpackage

// File: rtl/step_timer.sv
// Down-counter timing one PLAY or GAP phase; done pulses for one cycle at expiry.
// done is combinational from the count; load wins over expiry, clr cancels a running phase.
module step_timer #(
    parameter int CW      = 3,
    parameter int PLAY_LD = 5,
    parameter int GAP_LD  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic sel_gap,
    input  logic clr,
    output logic done
);

    logic [CW-1:0] cnt;
    logic          run;

    assign done = run && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (clr) begin
            run <= 1'b0;
        end else if (load) begin
            cnt <= sel_gap ? CW'(GAP_LD) : CW'(PLAY_LD);
            run <= 1'b1;
        end else if (done) begin
            run <= 1'b0;
        end else if (run) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/note_step_sequencer.sv
// Step sequencer sharing the active-low note bus between manual keys and pattern playback.
// All outputs registered (1 cycle); stop aborts on the next edge and outranks start/advance.
module note_step_sequencer
    import synth_pkg::*;
#(
    parameter int NNOTES   = NNOTES_DEF,
    parameter int NSTEPS   = 16,
    parameter int STEP_CYC = 4000000,
    parameter int GAP_CYC  = 400000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      loop,
    input  logic [$clog2(NSTEPS)-1:0] len,
    input  logic [NNOTES-1:0]         manual_enn,
    input  logic                      wr_en,
    input  logic [$clog2(NSTEPS)-1:0] wr_addr,
    input  logic [NNOTES-1:0]         wr_data,
    output logic [NNOTES-1:0]         note_enn,
    output logic                      busy,
    output logic [$clog2(NSTEPS)-1:0] step_idx,
    output logic                      step_pulse
);

    localparam int  SW       = $clog2(NSTEPS);
    localparam int  CW       = $clog2(STEP_CYC);
    localparam bit  HAS_GAP  = (GAP_CYC > 0);
    localparam int  PLAY_LD  = STEP_CYC - GAP_CYC - 1;
    localparam int  GAP_LD   = HAS_GAP ? GAP_CYC - 1 : 0;

    seq_state_t        state;
    logic [NNOTES-1:0] pattern [NSTEPS];

    logic          done;
    logic          go;
    logic          to_gap;
    logic          to_idle;
    logic          abort;
    logic [SW-1:0] go_idx;

    // Decide this edge's transition; go covers every PLAY entry (start, advance, wrap).
    always_comb begin
        go      = 1'b0;
        to_gap  = 1'b0;
        to_idle = 1'b0;
        abort   = 1'b0;
        go_idx  = '0;
        case (state)
            IDLE: begin
                go = start && !stop;
            end
            PLAY, GAP: begin
                if (stop) begin
                    abort = 1'b1;
                end else if (done) begin
                    if (HAS_GAP && state == PLAY) begin
                        to_gap = 1'b1;
                    end else if (step_idx < len) begin
                        go     = 1'b1;
                        go_idx = step_idx + 1'b1;
                    end else if (loop) begin
                        go = 1'b1;
                    end else begin
                        to_idle = 1'b1;
                    end
                end
            end
            default: abort = 1'b1;
        endcase
    end

    step_timer #(
        .CW      (CW),
        .PLAY_LD (PLAY_LD),
        .GAP_LD  (GAP_LD)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (go || to_gap),
        .sel_gap (to_gap),
        .clr     (abort || to_idle),
        .done    (done)
    );

    // The mask is read before this edge's write lands, so a same-edge write plays the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            note_enn   <= '1;
            busy       <= 1'b0;
            step_idx   <= '0;
            step_pulse <= 1'b0;
            for (int i = 0; i < NSTEPS; i++) begin
                pattern[i] <= '0;
            end
        end else begin
            step_pulse <= go;
            if (go) begin
                state    <= PLAY;
                step_idx <= go_idx;
                note_enn <= ~pattern[go_idx];
                busy     <= 1'b1;
            end else if (to_gap) begin
                state    <= GAP;
                note_enn <= '1;
            end else if (abort || to_idle) begin
                state    <= IDLE;
                note_enn <= '1;
                busy     <= 1'b0;
            end else if (state == IDLE) begin
                note_enn <= manual_enn;
            end
            if (wr_en) begin
                pattern[wr_addr] <= wr_data;
            end
        end
    end

endmodule
